// File: rtl/fetch_controller_pkg.sv
// Shared definitions for the fetch controller: state encoding and
// default widths of the program store interface.
package fetch_controller_pkg;

    // Default program store geometry and instruction width
    localparam int DEFAULT_ADDRESS_WIDTH      = 8;
    localparam int DEFAULT_PROGRAM_DATA_WIDTH = 17;

    // PC value used on reset and whenever fetching is (re)started
    localparam logic [DEFAULT_ADDRESS_WIDTH-1:0] DEFAULT_RESET_PC = 8'h00;

    // Controller state: idle, boot-time loading, or instruction fetch
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FETCH = 2'd2
    } state_t;

endpackage

// File: rtl/fetch_controller_pc.sv
// Program counter register: asynchronous reset, explicit value load
// (start / jump redirect) and wrapping increment (sequential advance).
module fetch_pc_reg #(
    parameter int                        ADDRESS_WIDTH = 8,
    parameter logic [ADDRESS_WIDTH-1:0]  RESET_PC      = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_set,
    input  logic [ADDRESS_WIDTH-1:0] i_setValue,
    input  logic                     i_incr,
    output logic [ADDRESS_WIDTH-1:0] o_pc
);

    logic [ADDRESS_WIDTH-1:0] r_pc;

    // A load takes precedence over increment; increment wraps naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else if (i_set) begin
            r_pc <= i_setValue;
        end else if (i_incr) begin
            r_pc <= r_pc + ADDRESS_WIDTH'(1);
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/fetch_controller.sv
// Fetch controller: owns the PC, shares the program store address bus
// between the boot loader and instruction fetch, and holds the IF/ID
// register feeding decode.
module fetch_controller
    import fetch_controller_pkg::*;
#(
    parameter int                        ADDRESS_WIDTH      = DEFAULT_ADDRESS_WIDTH,
    parameter int                        PROGRAM_DATA_WIDTH = DEFAULT_PROGRAM_DATA_WIDTH,
    parameter int                        NUM_ADDRESSES      = 2 ** ADDRESS_WIDTH,
    parameter logic [ADDRESS_WIDTH-1:0]  RESET_PC           = DEFAULT_RESET_PC
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          halt,
    input  logic                          load_req,
    input  logic                          load_valid,
    input  logic [PROGRAM_DATA_WIDTH-1:0] load_data,
    input  logic                          load_last,
    output logic                          load_ready,
    output logic                          load_done,
    output logic [ADDRESS_WIDTH-1:0]      mem_addr,
    output logic [PROGRAM_DATA_WIDTH-1:0] mem_wdata,
    output logic                          mem_we,
    input  logic [PROGRAM_DATA_WIDTH-1:0] mem_rdata,
    input  logic                          stall,
    input  logic                          redirect_valid,
    input  logic [ADDRESS_WIDTH-1:0]      redirect_pc,
    output logic [PROGRAM_DATA_WIDTH-1:0] instr,
    output logic [ADDRESS_WIDTH-1:0]      instr_pc,
    output logic                          instr_valid,
    output logic                          busy
);

    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(NUM_ADDRESSES - 1);

    state_t                          r_state;
    state_t                          w_nextState;
    logic [ADDRESS_WIDTH-1:0]        r_loadAddr;
    logic                            r_loadDone;
    logic [PROGRAM_DATA_WIDTH-1:0]   r_instr;
    logic [ADDRESS_WIDTH-1:0]        r_instrPc;
    logic                            r_instrValid;

    logic [ADDRESS_WIDTH-1:0]        w_pc;
    logic                            w_setPc;
    logic [ADDRESS_WIDTH-1:0]        w_setValue;
    logic                            w_incPc;
    logic                            w_loadAccept;
    logic                            w_loadExit;

    fetch_pc_reg #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .RESET_PC      (RESET_PC)
    ) u_pcReg (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_set      (w_setPc),
        .i_setValue (w_setValue),
        .i_incr     (w_incPc),
        .o_pc       (w_pc)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state, address/write mux and PC controls; halt > redirect > stall > advance in FETCH
    always_comb begin
        w_nextState  = r_state;
        load_ready   = 1'b0;
        mem_we       = 1'b0;
        mem_wdata    = '0;
        mem_addr     = w_pc;
        w_setPc      = 1'b0;
        w_setValue   = RESET_PC;
        w_incPc      = 1'b0;
        w_loadAccept = 1'b0;
        w_loadExit   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (load_req) begin
                    w_nextState = ST_LOAD;
                end else if (start) begin
                    w_nextState = ST_FETCH;
                    w_setPc     = 1'b1;
                    w_setValue  = RESET_PC;
                end
            end
            ST_LOAD: begin
                load_ready = 1'b1;
                mem_we     = load_valid;
                mem_addr   = r_loadAddr;
                mem_wdata  = load_data;
                if (load_valid) begin
                    w_loadAccept = 1'b1;
                    if (load_last || (r_loadAddr == LAST_ADDR)) begin
                        w_loadExit  = 1'b1;
                        w_nextState = ST_IDLE;
                    end
                end
            end
            ST_FETCH: begin
                if (halt) begin
                    w_nextState = ST_IDLE;
                end else if (redirect_valid) begin
                    w_setPc    = 1'b1;
                    w_setValue = redirect_pc;
                end else if (!stall) begin
                    w_incPc = 1'b1;
                end
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // Loader write address: cleared on entry, stops at the last address instead of wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_loadAddr <= '0;
        end else if ((r_state == ST_IDLE) && load_req) begin
            r_loadAddr <= '0;
        end else if (w_loadAccept && (r_loadAddr != LAST_ADDR)) begin
            r_loadAddr <= r_loadAddr + ADDRESS_WIDTH'(1);
        end
    end

    // One-cycle completion pulse in the cycle following the final accepted word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_loadDone <= 1'b0;
        end else begin
            r_loadDone <= w_loadExit;
        end
    end

    // IF/ID register: capture on advance, bubble on halt/redirect, hold on stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr      <= '0;
            r_instrPc    <= '0;
            r_instrValid <= 1'b0;
        end else if (r_state == ST_FETCH) begin
            if (halt || redirect_valid) begin
                r_instrValid <= 1'b0;
            end else if (!stall) begin
                r_instr      <= mem_rdata;
                r_instrPc    <= w_pc;
                r_instrValid <= 1'b1;
            end
        end else begin
            r_instrValid <= 1'b0;
        end
    end

    assign instr       = r_instr;
    assign instr_pc    = r_instrPc;
    assign instr_valid = r_instrValid;
    assign load_done   = r_loadDone;
    assign busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_fetch_controller.sv
// Directed testbench for fetch_controller with a behavioural program store.
module tb_fetch_controller;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        halt;
    logic        load_req;
    logic        load_valid;
    logic [16:0] load_data;
    logic        load_last;
    logic        load_ready;
    logic        load_done;
    logic [7:0]  mem_addr;
    logic [16:0] mem_wdata;
    logic        mem_we;
    logic [16:0] mem_rdata;
    logic        stall;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic [16:0] instr;
    logic [7:0]  instr_pc;
    logic        instr_valid;
    logic        busy;

    logic [16:0] store [256];

    int vectors;
    int miscompares;

    logic [16:0] words [4];

    fetch_controller dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .halt           (halt),
        .load_req       (load_req),
        .load_valid     (load_valid),
        .load_data      (load_data),
        .load_last      (load_last),
        .load_ready     (load_ready),
        .load_done      (load_done),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_we         (mem_we),
        .mem_rdata      (mem_rdata),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_valid    (instr_valid),
        .busy           (busy)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program store: synchronous write, combinational read
    always @(posedge clk) begin
        if (mem_we) store[mem_addr] <= mem_wdata;
    end
    assign mem_rdata = store[mem_addr];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic s, input logic h, input logic lr, input logic stl,
                                 input logic rv, input logic [7:0] rpc);
        start          = s;
        halt           = h;
        load_req       = lr;
        stall          = stl;
        redirect_valid = rv;
        redirect_pc    = rpc;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        words[0] = 17'h09200;
        words[1] = 17'h0b400;
        words[2] = 17'h0a088;
        words[3] = 17'h05000;
        for (int i = 0; i < 256; i++) store[i] = '0;

        rst_n      = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        load_last  = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        #3;
        checkOutput("rst_instr", 32'(instr), 32'h0);
        checkOutput("rst_instr_pc", 32'(instr_pc), 32'h0);
        checkOutput("rst_valid", 32'(instr_valid), 32'h0);
        checkOutput("rst_load_done", 32'(load_done), 32'h0);
        checkOutput("rst_load_ready", 32'(load_ready), 32'h0);
        checkOutput("rst_mem_we", 32'(mem_we), 32'h0);
        checkOutput("rst_mem_wdata", 32'(mem_wdata), 32'h0);
        checkOutput("rst_mem_addr", 32'(mem_addr), 32'h0);
        checkOutput("rst_busy", 32'(busy), 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Test 1: load four words
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput("t1_busy", 32'(busy), 32'h1);
        checkOutput("t1_ready", 32'(load_ready), 32'h1);
        for (int i = 0; i < 4; i++) begin
            load_valid = 1'b1;
            load_data  = words[i];
            load_last  = (i == 3);
            #1;
            checkOutput("t1_we", 32'(mem_we), 32'h1);
            checkOutput("t1_addr", 32'(mem_addr), 32'(i));
            checkOutput("t1_wdata", 32'(mem_wdata), 32'(words[i]));
            tick();
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        checkOutput("t1_done_pulse", 32'(load_done), 32'h1);
        checkOutput("t1_idle", 32'(busy), 32'h0);
        checkOutput("t1_ready_idle", 32'(load_ready), 32'h0);
        tick();
        checkOutput("t1_done_clear", 32'(load_done), 32'h0);
        for (int i = 0; i < 4; i++) checkOutput("t1_store", 32'(store[i]), 32'(words[i]));

        // Test 2: fetch the loaded program
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput("t2_busy", 32'(busy), 32'h1);
        checkOutput("t2_first_invalid", 32'(instr_valid), 32'h0);
        checkOutput("t2_addr0", 32'(mem_addr), 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("t2_instr", 32'(instr), 32'(words[i]));
            checkOutput("t2_instr_pc", 32'(instr_pc), 32'(i));
            checkOutput("t2_valid", 32'(instr_valid), 32'h1);
        end

        // Test 3: redirect to 0 while 0x05000 is presented
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput("t3_bubble", 32'(instr_valid), 32'h0);
        checkOutput("t3_addr", 32'(mem_addr), 32'h0);
        tick();
        checkOutput("t3_instr", 32'(instr), 32'h09200);
        checkOutput("t3_instr_pc", 32'(instr_pc), 32'h0);
        checkOutput("t3_valid", 32'(instr_valid), 32'h1);

        // Test 4: stall three cycles, then stall with redirect
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("t4_hold_instr", 32'(instr), 32'h09200);
            checkOutput("t4_hold_pc", 32'(instr_pc), 32'h0);
            checkOutput("t4_hold_valid", 32'(instr_valid), 32'h1);
            checkOutput("t4_hold_addr", 32'(mem_addr), 32'h1);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h02);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput("t4_redir_valid", 32'(instr_valid), 32'h0);
        checkOutput("t4_redir_addr", 32'(mem_addr), 32'h2);
        tick();
        checkOutput("t4_instr", 32'(instr), 32'h0a088);
        checkOutput("t4_instr_pc", 32'(instr_pc), 32'h2);

        // Test 5a: PC wrap from 0xFF to 0x00
        store[255] = 17'h1ABCD;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput("t5_addr_ff", 32'(mem_addr), 32'hFF);
        tick();
        checkOutput("t5_instr_ff", 32'(instr), 32'h1ABCD);
        checkOutput("t5_instr_pc_ff", 32'(instr_pc), 32'hFF);
        checkOutput("t5_wrap_addr", 32'(mem_addr), 32'h00);
        tick();
        checkOutput("t5_instr_wrap", 32'(instr), 32'h09200);
        checkOutput("t5_instr_pc_wrap", 32'(instr_pc), 32'h00);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput("t5_halt_busy", 32'(busy), 32'h0);
        checkOutput("t5_halt_valid", 32'(instr_valid), 32'h0);
        checkOutput("t5_halt_pc", 32'(mem_addr), 32'h01);

        // Test 5b: 257-word loader stream with no load_last
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 257; i++) begin
            load_valid = 1'b1;
            load_data  = 17'h10000 | 17'(i);
            #1;
            checkOutput("t5_ready", 32'(load_ready), (i < 256) ? 32'h1 : 32'h0);
            checkOutput("t5_we", 32'(mem_we), (i < 256) ? 32'h1 : 32'h0);
            if (i == 255) checkOutput("t5_last_addr", 32'(mem_addr), 32'hFF);
            if (i == 256) checkOutput("t5_done", 32'(load_done), 32'h1);
            tick();
        end
        load_valid = 1'b0;
        checkOutput("t5_done_clear", 32'(load_done), 32'h0);
        checkOutput("t5_store_00", 32'(store[0]), 32'h10000);
        checkOutput("t5_store_01", 32'(store[1]), 32'h10001);
        checkOutput("t5_store_80", 32'(store[128]), 32'h10080);
        checkOutput("t5_store_ff", 32'(store[255]), 32'h100FF);

        // Test 6: reset in the middle of a load
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) begin
            load_valid = 1'b1;
            load_data  = 17'h00100 + 17'(i);
            tick();
        end
        load_valid = 1'b0;
        checkOutput("t6_addr5", 32'(mem_addr), 32'h5);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_busy", 32'(busy), 32'h0);
        checkOutput("t6_ready", 32'(load_ready), 32'h0);
        checkOutput("t6_we", 32'(mem_we), 32'h0);
        checkOutput("t6_addr", 32'(mem_addr), 32'h0);
        checkOutput("t6_valid", 32'(instr_valid), 32'h0);
        checkOutput("t6_instr", 32'(instr), 32'h0);
        checkOutput("t6_done", 32'(load_done), 32'h0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checkOutput("t6_no_done", 32'(load_done), 32'h0);
        end
        for (int i = 0; i < 5; i++) checkOutput("t6_store", 32'(store[i]), 32'h00100 + 32'(i));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_controller.md
Name: fetch_controller

Overview:
- Sequences the program store: owns the program counter, drives the store's address bus and registers fetched instructions for decode.
- Shares the address bus between the fetch path and a boot-time program loader that writes instruction words into the store.
- Sits between the program store, whose write port is synchronous and whose read is combinational, and the decode stage.
- Decode feeds back stall and jump redirect, e.g. JMR.

Parameters:
ADDRESS_WIDTH, 8, program store address width
PROGRAM_DATA_WIDTH, 17, instruction word width
NUM_ADDRESSES, 256, program store depth (2**ADDRESS_WIDTH)
RESET_PC, 0, PC value loaded on reset and on start

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse; IDLE -> FETCH
halt  in  1  level; FETCH -> IDLE
load_req  in  1  pulse; IDLE -> LOAD
load_valid  in  1  loader word valid
load_data  in  PROGRAM_DATA_WIDTH  loader instruction word
load_last  in  1  qualifies final loader word
load_ready  out  1  controller accepts loader word
load_done  out  1  one-cycle pulse when load finishes
mem_addr  out  ADDRESS_WIDTH  program store address bus
mem_wdata  out  PROGRAM_DATA_WIDTH  program store write data
mem_we  out  1  program store write enable
mem_rdata  in  PROGRAM_DATA_WIDTH  program store combinational read data
stall  in  1  decode cannot accept; hold
redirect_valid  in  1  jump taken
redirect_pc  in  ADDRESS_WIDTH  jump target
instr  out  PROGRAM_DATA_WIDTH  registered instruction to decode
instr_pc  out  ADDRESS_WIDTH  address of instr
instr_valid  out  1  instr is valid
busy  out  1  state != IDLE

Behaviour:
- Reset, asynchronous, while rst_n=0:
  - state=IDLE, pc=RESET_PC, load_addr=0.
  - instr=0, instr_pc=0, instr_valid=0, load_done=0.
  - Combinational outputs in IDLE: load_ready=0, mem_we=0, mem_wdata=0, mem_addr=pc.
- States: IDLE, LOAD, FETCH (2-bit encoding).
- mem_addr mux: load_addr in LOAD, otherwise pc. mem_wdata=load_data in LOAD, else 0.
- IDLE:
  - load_req has priority over start.
  - load_req -> LOAD, load_addr<=0.
  - Otherwise start -> FETCH, pc<=RESET_PC.
  - instr_valid held 0.
- LOAD:
  - load_ready=1; mem_we = load_valid.
  - Write accepted on the edge where load_valid=1; load_addr increments by 1.
  - Leave for IDLE when the accepted word has load_last=1, or when load_addr = NUM_ADDRESSES-1 is written (no wrap, further words not accepted).
  - load_done=1 in the cycle after exit.
  - start, halt, redirect and stall are ignored in LOAD.
- FETCH, priority per cycle is halt > redirect_valid > stall > advance:
  - halt: -> IDLE, instr_valid<=0, pc unchanged.
  - redirect_valid: pc<=redirect_pc, instr_valid<=0 (one-cycle flush bubble); overrides stall.
  - stall: pc, instr, instr_pc and instr_valid all hold.
  - advance: instr<=mem_rdata, instr_pc<=pc, instr_valid<=1, pc<=pc+1 modulo NUM_ADDRESSES (255 -> 0).
  - Latency: instruction at address A appears on instr one cycle after mem_addr=A.
  - load_req and start are ignored in FETCH.
- Width rules: all PC arithmetic is ADDRESS_WIDTH bits, unsigned, wrapping. redirect_pc is taken verbatim.
- Reset mid-LOAD: words already written remain in the store; load_done is not pulsed.
- Reset mid-FETCH: instr_valid drops to 0 immediately (asynchronous).

Decomposition:
- Shared package holds:
  - state typedef/localparams ST_IDLE=0, ST_LOAD=1, ST_FETCH=2.
  - ADDRESS_WIDTH and PROGRAM_DATA_WIDTH defaults.
  - RESET_PC.
- One sub-module, fetch_pc_reg: the PC register with reset, load-value and increment controls.
- FSM, address mux and IF/ID register stay in the top.

Test Plan:
1. Reset, load_req, then 4 words 0x09200, 0x0b400, 0x0a088, 0x05000 with load_last on the 4th -> mem_we on 4 cycles at addr 0..3, load_done pulse, state IDLE, store contents match.
2. start after test 1 -> instr sequence 0x09200@0, 0x0b400@1, 0x0a088@2, 0x05000@3 on consecutive cycles with instr_valid=1; first valid one cycle after FETCH entry.
3. redirect_valid with redirect_pc=0 on the cycle instr=0x05000 is presented -> next cycle instr_valid=0, following cycle instr=0x09200, instr_pc=0.
4. stall held 3 cycles mid-stream, then redirect_valid asserted together with stall -> instr/instr_pc/instr_valid frozen for the stall cycles; redirect wins, pc=redirect_pc next cycle.
5. pc=0xFF, advance -> instr_pc=0xFF, then pc wraps to 0x00. Separately, a loader streaming 257 words with no load_last -> 256 writes, exit at addr 0xFF, 257th word not accepted (load_ready=0).
6. rst_n low for 1 cycle mid-LOAD at load_addr=5 -> outputs return to reset values immediately, load_done never pulses, addresses 0..4 retain data.
